// File: rtl/vpc_pkg.sv
// Shared types and constants for the vector player / response capture engine.
package vpc_pkg;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vpc_state_e;

  // Default MISR feedback taps (CRC-32 polynomial); narrower outputs use the low bits.
  localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

  // Widest vector index an apply tag can carry.
  localparam int TAG_IDX_W = 16;

  // Tag launched with every applied vector and delayed until its response is captured.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } apply_tag_t;

endpackage

// File: rtl/vpc_misr.sv
// Multiple-input signature register: compacts one captured response per enabled cycle.
module vpc_misr
  import vpc_pkg::*;
#(
  parameter int               OUT_W = 32,
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(MISR_POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [OUT_W-1:0] data,
  output logic [OUT_W-1:0] signature
);

  // Shift left with feedback from the MSB, then fold in the new response; clear wins.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values, independent of block order.
    if (rst || clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= {signature[OUT_W-2:0], 1'b0}
                 ^ (signature[OUT_W-1] ? POLY : '0)
                 ^ data;
    end
  end

endmodule

// File: rtl/vec_player_capture.sv
// Replays an on-chip vector memory into a combinational DUT, one vector per clock,
// and captures the responses a fixed number of cycles later into a stream and a MISR.
module vec_player_capture
  import vpc_pkg::*;
#(
  parameter int          IN_W      = 32,
  parameter int          OUT_W     = 32,
  parameter int          DEPTH     = 32,
  parameter int          ADDR_W    = $clog2(DEPTH),
  parameter int          CAP_DLY   = 1,
  parameter logic [31:0] MISR_POLY = MISR_POLY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [IN_W-1:0]   load_data,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              stop,
  input  logic [ADDR_W:0]   num_vec,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              cap_valid,
  output logic [OUT_W-1:0]  cap_data,
  output logic [ADDR_W-1:0] cap_index,
  output logic [OUT_W-1:0]  signature,
  output logic [15:0]       pass_cnt,
  output logic              busy,
  output logic              done
);

  localparam int             LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  vpc_state_e        state_q, state_d;
  logic [IN_W-1:0]   mem [DEPTH];
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] idx_q;
  apply_tag_t        pipe_q [CAP_DLY];
  apply_tag_t        new_tag;
  logic              launch, apply, last, drain_pending, load_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle strobes: launch a run, apply a vector, detect the pass end.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d       = state_q;
    launch        = 1'b0;
    apply         = 1'b0;
    last          = 1'b0;
    drain_pending = 1'b0;
    new_tag       = '0;
    // Any tag not yet in the final stage means a capture is still on its way.
    for (int i = 0; i < CAP_DLY - 1; i++) drain_pending = drain_pending | pipe_q[i].valid;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        apply       = 1'b1;
        last        = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
        new_tag.valid = 1'b1;
        new_tag.idx   = TAG_IDX_W'(idx_q);
        if (stop || (last && !loop_mode)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!drain_pending) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_ok = load_en && (state_q == IDLE) && ({1'b0, load_addr} < DEPTH_L);

  // Vector memory write port, only open while idle.
  always_ff @(posedge clk) begin
    // NOTE: the vector memory has no reset on purpose: contents survive rst and a plain RAM can be inferred.
    if (load_ok) mem[load_addr] <= load_data;
  end

  // Run datapath: length/index bookkeeping, vector drive, pass counting, capture delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      idx_q    <= '0;
      dut_in   <= '0;
      pass_cnt <= '0;
      for (int i = 0; i < CAP_DLY; i++) pipe_q[i] <= '0;
    end else begin
      if (launch) begin
        len_q    <= (num_vec > DEPTH_L) ? DEPTH_L : num_vec;
        idx_q    <= '0;
        pass_cnt <= '0;
      end
      if (apply) begin
        dut_in <= mem[idx_q];
        idx_q  <= last ? '0 : idx_q + ADDR_W'(1);
        if (last && (pass_cnt != 16'hFFFF)) pass_cnt <= pass_cnt + 16'd1;
      end
      pipe_q[0] <= new_tag;
      for (int i = 1; i < CAP_DLY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign cap_valid = pipe_q[CAP_DLY-1].valid;
  assign cap_index = pipe_q[CAP_DLY-1].idx[ADDR_W-1:0];
  assign cap_data  = cap_valid ? dut_out : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  vpc_misr #(
    .OUT_W (OUT_W),
    .POLY  (OUT_W'(MISR_POLY))
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch),
    .enable    (cap_valid),
    .data      (dut_out),
    .signature (signature)
  );

endmodule

// File: tb/tb_vec_player_capture.sv
// Randomised scoreboard bench: two engines (capture delay 1 and 3) share all control
// inputs; each drives its own behavioural 16x16 multiplier.
module tb_vec_player_capture;

  localparam int          DEPTH = 32;
  localparam logic [31:0] POLY  = 32'h04C11DB7;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst, load_en, start, loop_mode, stop;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic [5:0]  num_vec;

  logic [31:0] d1_dut_in, d1_dut_out, d1_cap_data, d1_signature;
  logic [4:0]  d1_cap_index;
  logic [15:0] d1_pass_cnt;
  logic        d1_cap_valid, d1_busy, d1_done;
  logic [31:0] d3_dut_in, d3_dut_out, d3_cap_data, d3_signature;
  logic [4:0]  d3_cap_index;
  logic [15:0] d3_pass_cnt;
  logic        d3_cap_valid, d3_busy, d3_done;

  logic [31:0] mem_m [DEPTH];
  exp_t        q1 [$];
  exp_t        q3 [$];
  int          cap1 = 0, cap3 = 0;
  int          n_checks = 0, n_pass = 0;

  function automatic logic [31:0] product(input logic [31:0] v);
    logic [31:0] a, b;
    a = {16'h0, v[31:16]};
    b = {16'h0, v[15:0]};
    return a * b;
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ d;
  endfunction

  assign d1_dut_out = product(d1_dut_in);
  assign d3_dut_out = product(d3_dut_in);

  vec_player_capture #(.IN_W(32), .OUT_W(32), .DEPTH(DEPTH), .CAP_DLY(1)) u_d1 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .loop_mode(loop_mode), .stop(stop), .num_vec(num_vec),
    .dut_in(d1_dut_in), .dut_out(d1_dut_out), .cap_valid(d1_cap_valid), .cap_data(d1_cap_data),
    .cap_index(d1_cap_index), .signature(d1_signature), .pass_cnt(d1_pass_cnt),
    .busy(d1_busy), .done(d1_done)
  );

  vec_player_capture #(.IN_W(32), .OUT_W(32), .DEPTH(DEPTH), .CAP_DLY(3)) u_d3 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .loop_mode(loop_mode), .stop(stop), .num_vec(num_vec),
    .dut_in(d3_dut_in), .dut_out(d3_dut_out), .cap_valid(d3_cap_valid), .cap_data(d3_cap_data),
    .cap_index(d3_cap_index), .signature(d3_signature), .pass_cnt(d3_pass_cnt),
    .busy(d3_busy), .done(d3_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Capture monitors: pop the expected response whenever an engine presents one.
  always @(negedge clk) begin : mon_d1
    exp_t e;
    if (d1_cap_valid === 1'b1) begin
      cap1++;
      if (q1.size() == 0) check("d1 unexpected capture", 1, 0);
      else begin
        e = q1.pop_front();
        check("d1 cap_index", d1_cap_index, e.idx);
        check("d1 cap_data", d1_cap_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_d3
    exp_t e;
    if (d3_cap_valid === 1'b1) begin
      cap3++;
      if (q3.size() == 0) check("d3 unexpected capture", 1, 0);
      else begin
        e = q3.pop_front();
        check("d3 cap_index", d3_cap_index, e.idx);
        check("d3 cap_data", d3_cap_data, e.data);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, " d1 outputs zero"},
          {d1_dut_in, d1_cap_data, d1_signature, d1_pass_cnt, d1_cap_index, d1_cap_valid, d1_busy, d1_done}, '0);
    check({tag, " d3 outputs zero"},
          {d3_dut_in, d3_cap_data, d3_signature, d3_pass_cnt, d3_cap_index, d3_cap_valid, d3_busy, d3_done}, '0);
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = 5'(addr);
    load_data = data;
    mem_m[addr] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One run. Cycle t = 0 is the first RUN cycle. stop_at / rst_at < 0 means "never".
  // poke drives start+load_en mid-run and start again during the CAP_DLY=1 engine's DONE.
  task automatic do_run(input string tag, input int nv, input bit lp, input int stop_at,
                        input int rst_at, input bit poke);
    int          len, napply, j, d;
    int          first_cap [2], done_r [2], done_n [2], low_r [2], cap0 [2], nexp [2];
    logic [31:0] sig_exp [2];
    logic [31:0] data;
    logic [1:0]  b, dn, cv;
    bit          finished;
    exp_t        e;

    len = (nv > DEPTH) ? DEPTH : nv;
    if (len == 0)          napply = 0;
    else if (stop_at >= 0) napply = lp ? stop_at + 1 : ((stop_at + 1 < len) ? stop_at + 1 : len);
    else if (lp)           napply = rst_at + 1;
    else                   napply = len;

    // Expected responses: capture k sees the vector on dut_in CAP_DLY cycles after apply k,
    // i.e. apply k+d-1, or the held last vector once the run has stopped applying.
    for (int u = 0; u < 2; u++) begin
      d = (u == 0) ? 1 : 3;
      sig_exp[u] = '0; nexp[u] = 0;
      first_cap[u] = -1; done_r[u] = -1; done_n[u] = 0; low_r[u] = -1;
      for (int k = 0; k < napply; k++) begin
        if (rst_at >= 0 && k + d > rst_at) break;
        j = (k + d - 1 < napply - 1) ? k + d - 1 : napply - 1;
        data   = product(mem_m[j % len]);
        e.idx  = k % len;
        e.data = data;
        if (u == 0) q1.push_back(e); else q3.push_back(e);
        sig_exp[u] = misr_next(sig_exp[u], data);
        nexp[u]++;
      end
    end
    cap0[0] = cap1; cap0[1] = cap3;

    num_vec   = 6'(nv);
    loop_mode = lp;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    finished  = 1'b0;
    load_addr = 5'd0;
    load_data = 32'hDEADBEEF;

    for (int t = 0; t < 400 && !finished; t++) begin
      b  = {d3_busy, d1_busy};
      dn = {d3_done, d1_done};
      cv = {d3_cap_valid, d1_cap_valid};
      for (int u = 0; u < 2; u++) begin
        if (cv[u] && first_cap[u] < 0) first_cap[u] = t;
        if (dn[u]) begin
          done_n[u]++;
          if (done_r[u] < 0) done_r[u] = t;
        end
        if (!b[u] && low_r[u] < 0) low_r[u] = t;
      end
      stop    = (t == stop_at);
      load_en = poke && (t == 1);
      start   = poke && ((t == 1) || dn[0]);
      if (rst_at >= 0) begin
        if (t == rst_at) rst = 1'b1;
        else if (t == rst_at + 1) begin
          rst = 1'b0;
          check_zero({tag, " after rst"});
          finished = 1'b1;
        end
      end else if (low_r[0] >= 0 && low_r[1] >= 0) begin
        finished = 1'b1;
      end
      if (!finished) @(negedge clk);
    end
    stop = 1'b0; start = 1'b0; load_en = 1'b0;
    if (!finished) check({tag, " run timeout"}, 0, 1);

    for (int u = 0; u < 2; u++) begin
      d = (u == 0) ? 1 : 3;
      check({tag, (u == 0) ? " d1" : " d3", " capture count"}, ((u == 0) ? cap1 : cap3) - cap0[u], nexp[u]);
      check({tag, (u == 0) ? " d1" : " d3", " leftover expected"}, (u == 0) ? q1.size() : q3.size(), 0);
      if (rst_at < 0) begin
        check({tag, (u == 0) ? " d1" : " d3", " first capture cycle"}, first_cap[u], (napply > 0) ? d : -1);
        check({tag, (u == 0) ? " d1" : " d3", " done pulses"}, done_n[u], 1);
        check({tag, (u == 0) ? " d1" : " d3", " done cycle"}, done_r[u], (napply > 0) ? napply + d : 0);
        check({tag, (u == 0) ? " d1" : " d3", " busy low cycle"}, low_r[u], ((napply > 0) ? napply + d : 0) + 1);
        check({tag, (u == 0) ? " d1" : " d3", " pass_cnt"}, (u == 0) ? d1_pass_cnt : d3_pass_cnt,
              (len > 0) ? napply / len : 0);
        check({tag, (u == 0) ? " d1" : " d3", " signature"}, (u == 0) ? d1_signature : d3_signature, sig_exp[u]);
      end else begin
        check({tag, (u == 0) ? " d1" : " d3", " done pulses"}, done_n[u], 0);
      end
    end
    q1.delete();
    q3.delete();
    @(negedge clk);
    check({tag, " idle after run"}, {d1_busy, d3_busy, d1_done, d3_done}, 4'b0);
  endtask

  initial begin
    int nv, sa;
    bit lp;
    rst = 1'b1; load_en = 1'b0; start = 1'b0; loop_mode = 1'b0; stop = 1'b0;
    load_addr = '0; load_data = '0; num_vec = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    load(0, 32'h00030005);
    load(1, 32'h00070009);
    load(2, 32'hFFFFFFFF);
    load(3, 32'h00000000);
    do_run("single", 4, 1'b0, -1, -1, 1'b1);
    do_run("loop_stop", 4, 1'b1, 9, -1, 1'b0);
    do_run("zero_len", 0, 1'b0, -1, -1, 1'b0);
    do_run("reset_mid", 4, 1'b1, -1, 6, 1'b0);
    do_run("rerun_single", 4, 1'b0, -1, -1, 1'b0);

    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    do_run("clamp", 40, 1'b0, -1, -1, 1'b0);
    do_run("stop_single", 32, 1'b0, 5, -1, 1'b0);

    for (int it = 0; it < 5; it++) begin
      lp = 1'($urandom_range(0, 1));
      nv = int'($urandom_range(1, 40));
      if (lp) sa = int'($urandom_range(0, 50));
      else    sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      do_run("random", nv, lp, sa, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
